// File: rtl/star_pkg.sv
// star_pkg: shared constants, FSM state encoding and exclusion-table entry
// layout for the star scanner.
//   No ports. Imported by star_scanner, star_exclusion_table and
//   address_translator.
package star_pkg;

  localparam int X_RES     = 60;
  localparam int Y_RES     = 60;
  localparam int XSZ       = 6;
  localparam int YSZ       = 6;
  localparam int MAX_STARS = 8;
  localparam int THRESHOLD = 0;
  localparam int AW        = 12;  // ROM address width (3600 words)
  localparam int CNTW      = 4;   // starCount width
  localparam int IDXW      = 3;   // table index width, log2(MAX_STARS)

  localparam logic [XSZ-1:0] X_LAST = 6'(X_RES - 1);
  localparam logic [YSZ-1:0] Y_LAST = 6'(Y_RES - 1);
  localparam logic [2:0]     PIX_BG = 3'(THRESHOLD);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_CHK      = 4'd2,
    ST_RUN_ADDR = 4'd3,
    ST_RUN_CHK  = 4'd4,
    ST_EMIT     = 4'd5,
    ST_ARM      = 4'd6,
    ST_WAIT     = 4'd7,
    ST_REC      = 4'd8,
    ST_DONE     = 4'd9
  } state_t;

  // One measured star box: horizontal run of its first row plus vertical span.
  typedef struct packed {
    logic [XSZ-1:0] x0;
    logic [XSZ-1:0] x1;
    logic [YSZ-1:0] top;
    logic [YSZ-1:0] bottom;
  } star_entry_t;

endpackage

// File: rtl/address_translator.sv
// address_translator: maps an (x, y) pixel coordinate of the 60-wide image
// onto the linear ROM address y*60 + x using shifts and adds.
//   x    in  XSZ  pixel column
//   y    in  YSZ  pixel row
//   addr out AW   linear word address
module address_translator
  import star_pkg::*;
(
  input  logic [XSZ-1:0] x,
  input  logic [YSZ-1:0] y,
  output logic [AW-1:0]  addr
);

  logic [AW-1:0] y64_s;
  logic [AW-1:0] y4_s;
  logic [AW-1:0] x_ext_s;

  // y*60 = y*64 - y*4
  assign y64_s   = {y, 6'b000000};
  assign y4_s    = {4'b0000, y, 2'b00};
  assign x_ext_s = {6'b000000, x};
  assign addr    = y64_s - y4_s + x_ext_s;

endmodule

// File: rtl/ram3600x3_sq.sv
// ram3600x3_sq: 3600 x 3-bit image memory with a registered read port
// (one-cycle read latency). The write port is tied off by the scanner.
//   address in  12  word address
//   clock   in  1   clock
//   data    in  3   write data
//   wren    in  1   write enable
//   q       out 3   registered read data
module ram3600x3_sq (
  input  logic [11:0] address,
  input  logic        clock,
  input  logic [2:0]  data,
  input  logic        wren,
  output logic [2:0]  q
);

  logic [2:0] mem [0:3599];

  // Synchronous write and registered read
  always_ff @(posedge clock) begin
    if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

endmodule

// File: rtl/star_exclusion_table.sv
// star_exclusion_table: boxes of stars already reported in this scan.
// Entries fill in order; hit is combinational over all valid entries.
//   clk, reset     in   clock, synchronous active-high reset
//   clear          in   drop all entries (new scan)
//   we             in   append {x0, x1, top, bottom}
//   x0, x1         in   XSZ  horizontal extent of the new entry
//   top, bottom    in   YSZ  vertical extent of the new entry
//   qx, qy         in   coordinate being classified
//   hit            out  qx,qy lies inside some valid box
//   count          out  CNTW number of valid entries
//   full           out  table holds MAX_STARS entries
module star_exclusion_table
  import star_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            we,
  input  logic [XSZ-1:0]  x0,
  input  logic [XSZ-1:0]  x1,
  input  logic [YSZ-1:0]  top,
  input  logic [YSZ-1:0]  bottom,
  input  logic [XSZ-1:0]  qx,
  input  logic [YSZ-1:0]  qy,
  output logic            hit,
  output logic [CNTW-1:0] count,
  output logic            full
);

  star_entry_t             entries_r [MAX_STARS];
  logic [MAX_STARS-1:0]    valid_r;
  logic [CNTW-1:0]         count_r;
  logic                    hit_s;

  assign count = count_r;
  assign full  = (count_r == 4'(MAX_STARS));
  assign hit   = hit_s;

  // Entry storage: cleared on reset or a new scan, appended on we
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_r <= {MAX_STARS{1'b0}};
      count_r <= 4'd0;
      for (int i = 0; i < MAX_STARS; i++) begin
        entries_r[i] <= 24'd0;
      end
    end else if (we && !full) begin
      entries_r[count_r[IDXW-1:0]] <= {x0, x1, top, bottom};
      valid_r[count_r[IDXW-1:0]]   <= 1'b1;
      count_r                      <= count_r + 4'd1;
    end
  end

  // Inclusive unsigned box test against every valid entry
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < MAX_STARS; i++) begin
      hit_s = hit_s | (valid_r[i]
                       & (qx >= entries_r[i].x0)  & (qx <= entries_r[i].x1)
                       & (qy >= entries_r[i].top) & (qy <= entries_r[i].bottom));
    end
  end

endmodule

// File: rtl/star_scanner.sv
// star_scanner: raster-scans the 60x60 image ROM for bright pixels, reports
// each new star's start coordinate with a one-cycle starFound pulse, waits
// for the downstream TopandBottomFound level and records the star's box so
// later pixels of the same star are skipped.
//   clk, reset         in   clock, synchronous active-high reset
//   start              in   begin a new scan (sampled in IDLE/DONE)
//   TopandBottomFound  in   downstream done level
//   mostTop/mostBottom in   YSZ vertical extent of current star
//   starFound          out  one-cycle pulse per new star
//   xOut, yOut         out  start coordinate of the reported star
//   starCount          out  4 stars recorded in this scan
//   scanDone           out  scan finished (level)
//   overflow           out  a star was found with the table full (level)
module star_scanner
  import star_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            TopandBottomFound,
  input  logic [YSZ-1:0]  mostTop,
  input  logic [YSZ-1:0]  mostBottom,
  output logic            starFound,
  output logic [XSZ-1:0]  xOut,
  output logic [YSZ-1:0]  yOut,
  output logic [3:0]      starCount,
  output logic            scanDone,
  output logic            overflow
);

  state_t         state_r, next_state_s;
  logic [XSZ-1:0] x_r, x_s, x0_r, x0_s, x1_r, x1_s, xout_r;
  logic [YSZ-1:0] y_r, y_s, y0_r, y0_s, yout_r;
  logic           overflow_r, overflow_s;
  logic           tbl_clear_s, tbl_we_s, hit_s, full_s;
  logic [AW-1:0]  addr_s;
  logic [2:0]     q_s;
  logic           bright_s, new_star_s, at_x_end_s, at_end_s;

  address_translator u_addr (.x(x_r), .y(y_r), .addr(addr_s));

  ram3600x3_sq u_rom (
    .address(addr_s), .clock(clk), .data(3'b000), .wren(1'b0), .q(q_s)
  );

  star_exclusion_table u_table (
    .clk(clk), .reset(reset), .clear(tbl_clear_s), .we(tbl_we_s),
    .x0(x0_r), .x1(x1_r), .top(mostTop), .bottom(mostBottom),
    .qx(x_r), .qy(y_r), .hit(hit_s), .count(starCount), .full(full_s)
  );

  assign bright_s   = (q_s != PIX_BG);
  assign new_star_s = bright_s & ~hit_s;
  assign at_x_end_s = (x_r == X_LAST);
  assign at_end_s   = at_x_end_s & (y_r == Y_LAST);
  assign xOut       = xout_r;
  assign yOut       = yout_r;
  assign overflow   = overflow_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: next_state_s = start ? ST_ADDR : state_r;
      ST_ADDR:          next_state_s = ST_CHK;
      ST_CHK: begin
        if (new_star_s) begin
          if (full_s)          next_state_s = ST_DONE;
          else if (at_x_end_s) next_state_s = ST_EMIT;
          else                 next_state_s = ST_RUN_ADDR;
        end else begin
          next_state_s = at_end_s ? ST_DONE : ST_ADDR;
        end
      end
      ST_RUN_ADDR:      next_state_s = ST_RUN_CHK;
      ST_RUN_CHK:       next_state_s = (bright_s && !at_x_end_s) ? ST_RUN_ADDR : ST_EMIT;
      ST_EMIT:          next_state_s = ST_ARM;
      // The previous star's done level may still be high here, so it is not looked at
      ST_ARM:           next_state_s = ST_WAIT;
      ST_WAIT:          next_state_s = TopandBottomFound ? ST_REC : ST_WAIT;
      ST_REC:           next_state_s = ((x1_r == X_LAST) && (y0_r == Y_LAST)) ? ST_DONE : ST_ADDR;
      default:          next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register
  always_comb begin
    starFound = 1'b0;
    scanDone  = 1'b0;
    case (state_r)
      ST_EMIT: starFound = 1'b1;
      ST_DONE: scanDone  = 1'b1;
      default: starFound = 1'b0;
    endcase
  end

  // Datapath next values: raster counters, star run bounds, table control
  always_comb begin
    x_s         = x_r;
    y_s         = y_r;
    x0_s        = x0_r;
    y0_s        = y0_r;
    x1_s        = x1_r;
    overflow_s  = overflow_r;
    tbl_clear_s = 1'b0;
    tbl_we_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          x_s         = 6'd0;
          y_s         = 6'd0;
          overflow_s  = 1'b0;
          tbl_clear_s = 1'b1;
        end else begin
          tbl_clear_s = 1'b0;
        end
      end
      ST_CHK: begin
        if (new_star_s) begin
          if (full_s) begin
            overflow_s = 1'b1;
          end else begin
            x0_s = x_r;
            y0_s = y_r;
            if (at_x_end_s) x1_s = x_r;
            else            x_s  = x_r + 6'd1;
          end
        end else if (at_x_end_s) begin
          x_s = 6'd0;
          y_s = at_end_s ? y_r : (y_r + 6'd1);
        end else begin
          x_s = x_r + 6'd1;
        end
      end
      ST_RUN_CHK: begin
        if (bright_s && !at_x_end_s) x_s  = x_r + 6'd1;
        else if (bright_s)           x1_s = x_r;
        else                         x1_s = x_r - 6'd1;
      end
      ST_REC: begin
        tbl_we_s = 1'b1;
        // Resume just right of the recorded run, wrapping at the row end
        if (x1_r == X_LAST) begin
          x_s = 6'd0;
          y_s = (y0_r == Y_LAST) ? y0_r : (y0_r + 6'd1);
        end else begin
          x_s = x1_r + 6'd1;
          y_s = y0_r;
        end
      end
      default: tbl_we_s = 1'b0;
    endcase
  end

  // Datapath registers; xOut/yOut load as the FSM enters EMIT
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r        <= 6'd0;
      y_r        <= 6'd0;
      x0_r       <= 6'd0;
      y0_r       <= 6'd0;
      x1_r       <= 6'd0;
      xout_r     <= 6'd0;
      yout_r     <= 6'd0;
      overflow_r <= 1'b0;
    end else begin
      x_r        <= x_s;
      y_r        <= y_s;
      x0_r       <= x0_s;
      y0_r       <= y0_s;
      x1_r       <= x1_s;
      overflow_r <= overflow_s;
      if (next_state_s == ST_EMIT) begin
        xout_r <= x0_s;
        yout_r <= y0_s;
      end
    end
  end

endmodule

// File: tb/tb_star_scanner.sv
// Testbench for star_scanner: loads images into the ROM, acts as the
// downstream mapTopandBottom stage and compares reported stars, counts and
// recorded boxes against a pixel-level reference model of the scan.
module tb_star_scanner;

  logic       clk = 1'b0;
  logic       reset, start, tbf;
  logic [5:0] most_top, most_bottom;
  logic       star_found, scan_done, ovf;
  logic [5:0] x_out, y_out;
  logic [3:0] star_count;

  always #5 clk = ~clk;

  star_scanner dut (
    .clk(clk), .reset(reset), .start(start), .TopandBottomFound(tbf),
    .mostTop(most_top), .mostBottom(most_bottom), .starFound(star_found),
    .xOut(x_out), .yOut(y_out), .starCount(star_count),
    .scanDone(scan_done), .overflow(ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] img [3600];
  int exp_x[$], exp_y[$], got_x[$], got_y[$];
  int box_x0[8], box_x1[8], box_top[8], box_bot[8];
  int n_box;
  bit exp_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit lit(int x, int y);
    return img[y*60 + x] != 3'd0;
  endfunction

  // Downstream answer: vertical extent of the star's first column
  function automatic int resp_bottom(int x, int y);
    int b = y;
    while (b < 59 && lit(x, b + 1)) b++;
    return b;
  endfunction

  function automatic bit in_box(int x, int y);
    for (int i = 0; i < n_box; i++) begin
      if (x >= box_x0[i] && x <= box_x1[i] && y >= box_top[i] && y <= box_bot[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference: walk pixels in raster order, report unexcluded bright pixels,
  // extend the run rightwards, then resume just past the run.
  task automatic build_expected();
    int p = 0;
    int x, y, x1;
    exp_x.delete(); exp_y.delete();
    n_box = 0; exp_ovf = 1'b0;
    while (p < 3600) begin
      x = p % 60; y = p / 60;
      if (lit(x, y) && !in_box(x, y)) begin
        if (n_box == 8) begin exp_ovf = 1'b1; break; end
        x1 = x;
        while (x1 < 59 && lit(x1 + 1, y)) x1++;
        exp_x.push_back(x); exp_y.push_back(y);
        box_x0[n_box] = x; box_x1[n_box] = x1;
        box_top[n_box] = y; box_bot[n_box] = resp_bottom(x, y);
        n_box++;
        p = y*60 + x1 + 1;
      end else begin
        p++;
      end
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 3600; i++) img[i] = 3'd0;
  endtask

  task automatic put(input int x, input int y, input int w, input int h, input logic [2:0] v);
    for (int j = y; j < y + h && j < 60; j++)
      for (int i = x; i < x + w && i < 60; i++)
        img[j*60 + i] = v;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 3600; i++) dut.u_rom.mem[i] <= img[i];
    @(negedge clk);
  endtask

  // Start a scan, answer each starFound like the downstream stage (its done
  // level stays high through ARM, then drops and re-rises with new data).
  task automatic run_scan(input string tag, input int abort_at, output int cyc);
    int phase = 0;
    int cnt = 0;
    bit done = 1'b0;
    build_expected();
    got_x.delete(); got_y.delete();
    cyc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (phase == 1) begin
        cnt--;
        if (cnt == 0) begin
          tbf = 1'b0;
          most_top = 6'($urandom);
          most_bottom = 6'($urandom);
          cnt = $urandom_range(1, 4);
          phase = 2;
        end
      end else if (phase == 2) begin
        cnt--;
        if (cnt == 0) begin
          tbf = 1'b1;
          most_top = 6'(got_y[$]);
          most_bottom = 6'(resp_bottom(got_x[$], got_y[$]));
          phase = 0;
        end
      end
      if (star_found) begin
        got_x.push_back(int'(x_out));
        got_y.push_back(int'(y_out));
        phase = 1;
        cnt = 2;
        if (abort_at > 0 && got_x.size() == abort_at) begin
          tbf = 1'b0;
          repeat (6) @(negedge clk);
          done = 1'b1;
        end
      end
      if (scan_done) done = 1'b1;
    end
    if (abort_at == 0) begin
      check({tag, "_done"}, 32'(scan_done), 32'd1);
      check({tag, "_nstars"}, 32'(got_x.size()), 32'(exp_x.size()));
      for (int i = 0; i < exp_x.size() && i < got_x.size(); i++)
        check({tag, "_xy"}, 32'(got_x[i]*64 + got_y[i]), 32'(exp_x[i]*64 + exp_y[i]));
      check({tag, "_count"}, 32'(star_count), 32'(n_box));
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      check({tag, "_valid"}, 32'(dut.u_table.valid_r), 32'((1 << n_box) - 1));
      for (int i = 0; i < n_box; i++)
        check({tag, "_entry"}, 32'(dut.u_table.entries_r[i]),
              32'((box_x0[i] << 18) | (box_x1[i] << 12) | (box_top[i] << 6) | box_bot[i]));
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    reset = 1'b1; start = 1'b0; tbf = 1'b0;
    most_top = 6'd0; most_bottom = 6'd0;
    clear_img();
    load_rom();
    repeat (3) @(negedge clk);
    check("rst_found", 32'(star_found), 32'd0);
    check("rst_xout", 32'(x_out), 32'd0);
    check("rst_yout", 32'(y_out), 32'd0);
    check("rst_count", 32'(star_count), 32'd0);
    check("rst_done", 32'(scan_done), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // All-black image: full raster of 2 cycles per pixel
    run_scan("black", 0, cyc);
    check("black_cycles", 32'(cyc >= 7198 && cyc <= 7202), 32'd1);

    // Single 3x3 star
    clear_img(); put(10, 5, 3, 3, 3'd5); load_rom();
    run_scan("single", 0, cyc);

    // Two stars in raster order
    clear_img(); put(4, 2, 1, 1, 3'd7); put(50, 40, 2, 2, 3'd2); load_rom();
    run_scan("two", 0, cyc);

    // Run touching the right edge, plus the final pixel
    clear_img(); put(57, 20, 3, 1, 3'd1); put(59, 59, 1, 1, 3'd4); load_rom();
    run_scan("edge", 0, cyc);

    // Nine isolated stars overflow the eight-entry table
    clear_img();
    for (int i = 0; i < 9; i++) put(i*6, 10, 1, 1, 3'd6);
    load_rom();
    run_scan("nine", 0, cyc);

    // Reset while waiting on the second star
    clear_img(); put(4, 2, 1, 1, 3'd3); put(30, 30, 2, 1, 3'd3); load_rom();
    run_scan("rstw", 2, cyc);
    check("rstw_pre_count", 32'(star_count), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rstw_found", 32'(star_found), 32'd0);
    check("rstw_xout", 32'(x_out), 32'd0);
    check("rstw_yout", 32'(y_out), 32'd0);
    check("rstw_count", 32'(star_count), 32'd0);
    check("rstw_done", 32'(scan_done), 32'd0);
    check("rstw_ovf", 32'(ovf), 32'd0);
    check("rstw_valid", 32'(dut.u_table.valid_r), 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (star_found) pulses++;
    end
    check("rstw_no_pulse", 32'(pulses), 32'd0);

    // Random images of overlapping rectangles and loose pixels
    for (int r = 0; r < 4; r++) begin
      clear_img();
      for (int k = 0; k < int'($urandom_range(1, 7)); k++)
        put($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(1, 4),
            $urandom_range(1, 4), 3'($urandom_range(1, 7)));
      load_rom();
      run_scan("rand", 0, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/star_scanner.md
Name: star_scanner

Overview:
- Upstream stage of mapTopandBottom.
- Raster-scans the 60x60 3-bit image ROM (ram3600x3_sq) for non-black pixels. On each new star it drives the start coordinate and a one-cycle starFound pulse into mapTopandBottom, then waits for TopandBottomFound.
- Keeps a small table of found-star boxes so pixels of an already-measured star are not reported again.

Parameters:
- X_RES, 60, image width in pixels.
- Y_RES, 60, image height in pixels.
- XSZ, 6, x coordinate width.
- YSZ, 6, y coordinate width.
- MAX_STARS, 8, exclusion-table depth.
- THRESHOLD, 0, pixel value treated as background.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE/DONE, begins a new scan from (0,0) and clears the table.
- TopandBottomFound  in  1  done level from mapTopandBottom.
- mostTop  in  YSZ  top row of the current star, valid while TopandBottomFound=1.
- mostBottom  in  YSZ  bottom row of the current star, valid while TopandBottomFound=1.
- starFound  out  1  one-cycle pulse per new star.
- xOut  out  XSZ  star start x; held from the pulse until the star is recorded.
- yOut  out  YSZ  star start y; same hold rule as xOut.
- starCount  out  4  number of stars recorded in this scan.
- scanDone  out  1  level; scan finished (end of image or table overflow).
- overflow  out  1  level; a star was found while the table was full.

Behaviour:
Reset:
- State IDLE.
- All outputs 0.
- Table valid bits cleared.
- x/y counters 0.

Address and ROM:
- addr = y*60 + x, via the same shift-add form as address_translator.
- ROM read is synchronous, 1-cycle latency. Each pixel therefore takes 2 cycles: an ADDR state presents the address, a CHK state evaluates q.

Pixel classification:
- Bright = (q != THRESHOLD).
- Excluded = some valid entry i has x0_i <= x <= x1_i and top_i <= y <= bottom_i. All comparisons unsigned, combinational over all entries.

FSM states and transitions:
- IDLE: start -> ADDR with x=y=0, table cleared, starCount=0, overflow=0, scanDone=0.
- ADDR -> CHK.
- CHK:
  - Bright and not excluded, table full -> set overflow, then DONE.
  - Bright and not excluded, table not full -> latch x0=x, y0=y. If x==X_RES-1 then x1=x and go to EMIT; otherwise x++ and go to RUN_ADDR.
  - Otherwise advance the raster: x++, or x=0 and y++ at x==X_RES-1. After (X_RES-1, Y_RES-1) go to DONE, else ADDR.
- RUN_ADDR -> RUN_CHK.
- RUN_CHK:
  - Bright and x<X_RES-1 -> x++, go to RUN_ADDR.
  - Bright and x==X_RES-1 -> x1=x, go to EMIT.
  - Not bright -> x1=x-1, go to EMIT.
  - The run ignores exclusion.
- EMIT: starFound=1 for exactly this cycle; xOut=x0, yOut=y0 -> ARM.
- ARM: one cycle with TopandBottomFound ignored, because the downstream flag from the previous star is still high here -> WAIT.
- WAIT: stay until TopandBottomFound=1 -> REC.
- REC:
  - Write entry {x0, x1, mostTop, mostBottom} and set its valid bit; starCount++.
  - Resume the raster at (x1+1, y0), wrapping to the next row if x1==X_RES-1; the end-of-image rule applies -> ADDR or DONE.
- DONE: scanDone=1 (held) and starFound=0; start -> IDLE-style restart next cycle.

Boundary conditions:
- Reset mid-scan or mid-handshake returns to IDLE on the next edge. No starFound pulse is emitted after reset.
- start is ignored outside IDLE/DONE.
- A star touching the right edge has x1=59.
- A star at (59,59) is emitted, and the scan finishes after REC.
- A TopandBottomFound level still high from a prior star is never mistaken for completion (guaranteed by ARM).
- Table entries persist until the next start or reset.
- Known limitation: a star that widens below its first row may be partially re-reported.

Decomposition:
- Package star_pkg: XSZ, YSZ, X_RES, Y_RES, THRESHOLD, MAX_STARS; state encoding localparams; entry field widths.
- Sub-module star_exclusion_table: MAX_STARS entries with write port (we, x0, x1, top, bottom) and combinational hit(x, y), clear, count/full outputs.
- Reuse the existing address_translator and ram3600x3_sq.

Test Plan:
- All-black image, start pulse -> no starFound; scanDone rises 7200±2 cycles after start; starCount=0.
- Single 3x3 star at x=10..12, y=5..7; model downstream returns top=5, bottom=7 -> exactly one starFound with xOut=10, yOut=5; entry {10,12,5,7}; starCount=1; scanDone.
- Two stars, at (4,2) 1 px wide and at (50,40) 2x2 -> pulses in raster order, (4,2) then (50,40); starCount=2.
- Star with right edge at x=57..59, y=20 -> x1=59; scan resumes at (0,21); no duplicate pulse.
- TopandBottomFound held high from the previous star through ARM -> scanner stays in WAIT until the model re-asserts; mostTop/mostBottom captured only then.
- Nine separated 1-px stars with MAX_STARS=8 -> eight pulses, then overflow=1 and scanDone=1 at the ninth; reset asserted mid-WAIT in a separate run -> all outputs 0 next cycle.
